// File: rtl/alu4_acc.sv
// rtl/alu4_acc.sv - 4-bit add/sub accumulator with valid/ready command and result handshakes
// Optional saturating ADD/SUB: define ALU4_ACC_SAT_EN.
module alu4_acc #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [3:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       acc,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_CMP  = 2'b11;

  logic       accept;
  logic       sub;
  logic [3:0] real_b;
  logic [4:0] sum;
  logic [3:0] y;
  logic       sum_ovf;
  logic [3:0] arith_acc;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // SUB and CMP both encode with in_op[1] set; LOAD ignores the adder.
  assign sub     = in_op[1];
  assign real_b  = in_data ^ {4{sub}};
  assign sum     = {1'b0, acc} + {1'b0, real_b} + {4'b0000, sub};
  assign y       = sum[3:0];
  assign sum_ovf = (acc[3] == real_b[3]) && (y[3] != acc[3]);

`ifdef ALU4_ACC_SAT_EN
  always_comb begin
    arith_acc = y;
    if (sum_ovf) arith_acc = acc[3] ? 4'b1000 : 4'b0111;
  end
`else
  assign arith_acc = y;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc        <= 4'd0;
      carry      <= 1'b0;
      zero       <= 1'b1;
      overflow   <= 1'b0;
      ovf_sticky <= 1'b0;
      op_count   <= '0;
      out_valid  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      if (in_op == OP_LOAD) begin
        acc        <= in_data;
        carry      <= 1'b0;
        overflow   <= 1'b0;
        zero       <= (in_data == 4'd0);
        ovf_sticky <= 1'b0;
      end else begin
        carry    <= sum[4];
        overflow <= sum_ovf;
        if (sum_ovf) ovf_sticky <= 1'b1;
        if (op_count != {CNT_W{1'b1}}) op_count <= op_count + 1'b1;
        if (in_op == OP_CMP) begin
          zero <= (y == 4'd0);
        end else begin
          acc  <= arith_acc;
          zero <= (arith_acc == 4'd0);
        end
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu4_acc.sv
// tb/tb_alu4_acc.sv - directed self-checking bench for alu4_acc (honours ALU4_ACC_SAT_EN)
module tb_alu4_acc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_op = 2'b00;
  logic [3:0] in_data = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] acc;
  logic       carry, zero, overflow, ovf_sticky;
  logic [7:0] op_count;

  int passed = 0;
  int total  = 0;

  alu4_acc #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .acc(acc), .carry(carry), .zero(zero), .overflow(overflow),
    .ovf_sticky(ovf_sticky), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] d);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    total++;
    if ({acc, carry, zero, overflow, ovf_sticky, out_valid, in_ready} !== {4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_flags: got acc=%h c=%b z=%b o=%b s=%b ov=%b ir=%b, want acc=0 c=0 z=1 o=0 s=0 ov=0 ir=1",
               acc, carry, zero, overflow, ovf_sticky, out_valid, in_ready);
    else passed++;
    total++;
    if (op_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", op_count);
    else passed++;
  endtask

  task automatic test_pos_overflow();
    logic [3:0] exp_acc;
`ifdef ALU4_ACC_SAT_EN
    exp_acc = 4'b0111;
`else
    exp_acc = 4'b1000;
`endif
    send(2'b00, 4'd7);
    total++;
    if ({acc, zero, out_valid} !== {4'd7, 1'b0, 1'b1})
      $display("FAIL load7: got acc=%h z=%b ov=%b want acc=7 z=0 ov=1", acc, zero, out_valid);
    else passed++;
    send(2'b01, 4'd1);
    total++;
    if (acc !== exp_acc) $display("FAIL add_ovf_acc: got %h want %h", acc, exp_acc);
    else passed++;
    total++;
    if ({carry, overflow, zero, ovf_sticky, out_valid} !== 5'b01011)
      $display("FAIL add_ovf_flags: got c=%b o=%b z=%b s=%b ov=%b want c=0 o=1 z=0 s=1 ov=1",
               carry, overflow, zero, ovf_sticky, out_valid);
    else passed++;
    total++;
    if (op_count !== 8'd1) $display("FAIL add_ovf_count: got %0d want 1", op_count);
    else passed++;
  endtask

  task automatic test_equal_sub();
    send(2'b00, 4'd3);
    total++;
    if (ovf_sticky !== 1'b0) $display("FAIL load_clears_sticky: got %b want 0", ovf_sticky);
    else passed++;
    send(2'b10, 4'd3);
    total++;
    if ({acc, zero, carry, overflow} !== {4'd0, 1'b1, 1'b1, 1'b0})
      $display("FAIL sub_equal: got acc=%h z=%b c=%b o=%b want acc=0 z=1 c=1 o=0", acc, zero, carry, overflow);
    else passed++;
  endtask

  task automatic test_borrow();
    send(2'b00, 4'd0);
    send(2'b10, 4'd1);
    total++;
    if ({acc, zero, carry, overflow} !== {4'hF, 1'b0, 1'b0, 1'b0})
      $display("FAIL sub_borrow: got acc=%h z=%b c=%b o=%b want acc=f z=0 c=0 o=0", acc, zero, carry, overflow);
    else passed++;
    total++;
    if (op_count !== 8'd3) $display("FAIL borrow_count: got %0d want 3", op_count);
    else passed++;
  endtask

  task automatic test_backpressure_cmp();
    step();  // drain the pending result
    total++;
    if (out_valid !== 1'b0) $display("FAIL drain: got out_valid=%b want 0", out_valid);
    else passed++;
    out_ready = 1'b0;
    send(2'b00, 4'd5);
    total++;
    if ({out_valid, in_ready, acc} !== {1'b1, 1'b0, 4'd5})
      $display("FAIL bp_load: got ov=%b ir=%b acc=%h want ov=1 ir=0 acc=5", out_valid, in_ready, acc);
    else passed++;
    in_valid = 1'b1;
    in_op    = 2'b01;
    in_data  = 4'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({out_valid, in_ready, acc, zero, op_count} !== {1'b1, 1'b0, 4'd5, 1'b0, 8'd3})
        $display("FAIL bp_hold[%0d]: got ov=%b ir=%b acc=%h z=%b cnt=%0d want ov=1 ir=0 acc=5 z=0 cnt=3",
                 i, out_valid, in_ready, acc, zero, op_count);
      else passed++;
    end
    out_ready = 1'b1;
    in_op     = 2'b11;
    in_data   = 4'd5;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL bp_ready_comb: got %b want 1", in_ready);
    else passed++;
    step();
    in_valid = 1'b0;
    total++;
    if ({acc, zero, carry, overflow, out_valid} !== {4'd5, 1'b1, 1'b1, 1'b0, 1'b1})
      $display("FAIL cmp: got acc=%h z=%b c=%b o=%b ov=%b want acc=5 z=1 c=1 o=0 ov=1",
               acc, zero, carry, overflow, out_valid);
    else passed++;
    total++;
    if (op_count !== 8'd4) $display("FAIL cmp_count: got %0d want 4", op_count);
    else passed++;
  endtask

  task automatic test_saturation_reset();
    in_valid = 1'b1;
    in_op    = 2'b01;
    in_data  = 4'd0;
    for (int i = 0; i < 300; i++) step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total++;
    if ({op_count, acc, out_valid} !== {8'd255, 4'd5, 1'b1})
      $display("FAIL count_sat: got cnt=%0d acc=%h ov=%b want cnt=255 acc=5 ov=1", op_count, acc, out_valid);
    else passed++;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    total++;
    if ({out_valid, acc, carry, zero, overflow, ovf_sticky, op_count} !== {1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0})
      $display("FAIL mid_reset: got ov=%b acc=%h c=%b z=%b o=%b s=%b cnt=%0d want ov=0 acc=0 c=0 z=1 o=0 s=0 cnt=0",
               out_valid, acc, carry, zero, overflow, ovf_sticky, op_count);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_last;
`ifdef ALU4_ACC_SAT_EN
    exp_last = 4'd7;
`else
    exp_last = 4'd9;
`endif
    send(2'b00, 4'd2);
    total++;
    if ({acc, out_valid} !== {4'd2, 1'b1}) $display("FAIL b2b_0: got acc=%h ov=%b want acc=2 ov=1", acc, out_valid);
    else passed++;
    send(2'b01, 4'd3);
    total++;
    if ({acc, out_valid, overflow} !== {4'd5, 1'b1, 1'b0})
      $display("FAIL b2b_1: got acc=%h ov=%b o=%b want acc=5 ov=1 o=0", acc, out_valid, overflow);
    else passed++;
    send(2'b01, 4'd4);
    total++;
    if ({acc, overflow, carry, ovf_sticky, op_count} !== {exp_last, 1'b1, 1'b0, 1'b1, 8'd2})
      $display("FAIL b2b_2: got acc=%h o=%b c=%b s=%b cnt=%0d want acc=%h o=1 c=0 s=1 cnt=2",
               acc, overflow, carry, ovf_sticky, op_count, exp_last);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_pos_overflow();
    test_equal_sub();
    test_borrow();
    test_backpressure_cmp();
    test_saturation_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
